// File: rtl/usb_ls_rx_decoder.sv
// Low-speed USB receive front end: pad synchronizer, bit-clock recovery,
// NRZI decode, sync detection, bit unstuffing and EOP/error signalling.
module usb_ls_rx_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PHASE = 3
) (
    input  logic       usbclk,
    input  logic       usbrst_n,
    input  logic       usb_dp,
    input  logic       usb_dm,
    output logic [1:0] line_state,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_eop,
    output logic       rx_err
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [1:0] LS_J = 2'b10, LS_K = 2'b01, LS_SE0 = 2'b00, LS_SE1 = 2'b11;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, WAIT_IDLE} state_e;

    state_e           state_q, state_d;
    logic [1:0]       meta_q, line_q, line_last_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, idle_cnt_q, idle_cnt_d;
    logic [1:0]       prev_q, prev_d;
    logic [2:0]       zeros_q, zeros_d, ones_q, ones_d, bits_q, bits_d;
    logic [7:0]       shift_q, shift_d, data_q, data_d;
    logic             valid_q, valid_d, eop_q, eop_d, err_q, err_d;
    logic             sample, dbit;

    // Reload is keyed off the first sync stage so the counter reads 0 on the
    // very first cycle line_state shows the new level.
    always_comb begin
        if (meta_q != line_q)                             cnt_d = '0;
        else if (cnt_q == CNT_W'(CLKS_PER_BIT - 1))       cnt_d = '0;
        else                                              cnt_d = cnt_q + 1'b1;
    end

    assign sample = (cnt_q == CNT_W'(SAMPLE_PHASE));
    assign dbit   = (line_q == prev_q);

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        zeros_d    = zeros_q;
        ones_d     = ones_q;
        bits_d     = bits_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        eop_d      = 1'b0;
        err_d      = 1'b0;
        idle_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (line_q == LS_K && line_last_q == LS_J) begin
                    state_d = SYNC;
                    prev_d  = LS_J;
                    zeros_d = 3'd0;
                end
            end
            SYNC: begin
                if (sample) begin
                    if (line_q == LS_SE0 || line_q == LS_SE1) begin
                        err_d   = 1'b1;
                        state_d = WAIT_IDLE;
                    end else begin
                        prev_d = line_q;
                        if (!dbit) begin
                            if (zeros_q != 3'd7) zeros_d = zeros_q + 3'd1;
                        end else if (zeros_q >= 3'd5) begin
                            state_d = DATA;
                            bits_d  = 3'd0;
                            ones_d  = 3'd0;
                        end else begin
                            err_d   = 1'b1;
                            state_d = WAIT_IDLE;
                        end
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    if (line_q == LS_SE1) begin
                        err_d   = 1'b1;
                        state_d = WAIT_IDLE;
                    end else if (line_q == LS_SE0) begin
                        eop_d   = 1'b1;
                        err_d   = (bits_q != 3'd0);
                        state_d = WAIT_IDLE;
                    end else begin
                        prev_d = line_q;
                        if (ones_q == 3'd6) begin
                            // Stuff slot: a 0 is dropped, a 1 is a stuffing violation.
                            if (dbit) begin
                                err_d   = 1'b1;
                                state_d = WAIT_IDLE;
                            end else begin
                                ones_d = 3'd0;
                            end
                        end else begin
                            ones_d  = dbit ? ones_q + 3'd1 : 3'd0;
                            shift_d = {dbit, shift_q[7:1]};
                            bits_d  = bits_q + 3'd1;
                            if (bits_q == 3'd7) begin
                                data_d  = {dbit, shift_q[7:1]};
                                valid_d = 1'b1;
                            end
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                if (line_q == LS_J) begin
                    if (idle_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) state_d = IDLE;
                    else                                        idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            state_q     <= IDLE;
            meta_q      <= 2'b00;
            line_q      <= 2'b00;
            line_last_q <= 2'b00;
            cnt_q       <= '0;
            idle_cnt_q  <= '0;
            prev_q      <= 2'b00;
            zeros_q     <= 3'd0;
            ones_q      <= 3'd0;
            bits_q      <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            eop_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            meta_q      <= {usb_dm, usb_dp};
            line_q      <= meta_q;
            line_last_q <= line_q;
            cnt_q       <= cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            prev_q      <= prev_d;
            zeros_q     <= zeros_d;
            ones_q      <= ones_d;
            bits_q      <= bits_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            eop_q       <= eop_d;
            err_q       <= err_d;
        end
    end

    assign line_state = line_q;
    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign rx_eop     = eop_q;
    assign rx_err     = err_q;
    assign rx_active  = (state_q == DATA);

endmodule
